// File: rtl/register_scoreboard.sv
// Purpose : pending-write scoreboard for long-latency producers; stalls decode on RAW/WAW hazards.
// Latency : stall is combinational; busy/pending_cnt/err_timeout update one cycle after issue/writeback.
// Backpr. : stall holds decode; writeback is never blocked and a same-cycle writeback bypasses the stall.
//
// Ports:
//   clk, rst                       core clock, synchronous active-high reset
//   id_rs1/id_rs2 (+ _used)        decode source registers and whether they are read
//   id_rd, id_valid, id_long_lat   decode destination, valid, long-latency producer flag
//   flush                          kills the decode instruction this cycle (no issue, no stall)
//   wb_valid, wb_rd                long-latency writeback completion
//   stall                          hold decode
//   busy                           per-register pending-write bits (registered)
//   pending_cnt                    popcount of busy (registered)
//   err_timeout                    sticky: some register stayed busy for TIMEOUT cycles
module register_scoreboard #(
    parameter int NREGS   = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_valid,
    input  logic             id_long_lat,
    input  logic             flush,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    output logic             stall,
    output logic [NREGS-1:0] busy,
    output logic [REG_W:0]   pending_cnt,
    output logic             err_timeout
);

    localparam int AW = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] AGE_MAX = AW'(TIMEOUT);

    logic [NREGS-1:0] wb_hit;
    logic [NREGS-1:0] eff_busy;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] busy_next;
    logic [REG_W:0]   cnt_next;
    logic             issue;
    logic             timeout_hit;
    logic [AW-1:0]    age [NREGS];

    always_comb begin
        wb_hit   = wb_valid ? (NREGS'(1) << wb_rd) : '0;
        // Register file is write-before-read, so a result landing this cycle is already visible.
        eff_busy = busy & ~wb_hit;

        stall = id_valid & ~flush &
                ((id_rs1_used & eff_busy[id_rs1]) |
                 (id_rs2_used & eff_busy[id_rs2]) |
                 (id_long_lat & eff_busy[id_rd]));

        issue   = id_valid & ~stall & ~flush & id_long_lat & (id_rd != '0);
        set_vec = issue ? (NREGS'(1) << id_rd) : '0;

        // Set wins over a same-cycle clear: the new producer is younger than the one completing.
        busy_next    = (busy & ~wb_hit) | set_vec;
        busy_next[0] = 1'b0;

        cnt_next = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_next = cnt_next + (REG_W+1)'(busy_next[i]);
        end

        timeout_hit = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (busy[i] && (age[i] == AGE_MAX)) begin
                timeout_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= '0;
            pending_cnt <= '0;
            err_timeout <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                age[i] <= '0;
            end
        end else begin
            busy        <= busy_next;
            pending_cnt <= cnt_next;
            err_timeout <= err_timeout | timeout_hit;
            for (int i = 0; i < NREGS; i++) begin
                if (set_vec[i] || wb_hit[i]) begin
                    age[i] <= '0;
                end else if (busy[i] && (age[i] != AGE_MAX)) begin
                    age[i] <= age[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_register_scoreboard.sv
module tb_register_scoreboard;

    localparam int NREGS   = 32;
    localparam int REG_W   = 5;
    localparam int TIMEOUT = 255;

    localparam int K_STALL = 0;
    localparam int K_BUSY  = 1;
    localparam int K_CNT   = 2;
    localparam int K_ERR   = 3;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [REG_W-1:0] id_rd;
    logic             id_valid;
    logic             id_long_lat;
    logic             flush;
    logic             wb_valid;
    logic [REG_W-1:0] wb_rd;
    logic             stall;
    logic [NREGS-1:0] busy;
    logic [REG_W:0]   pending_cnt;
    logic             err_timeout;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];

    register_scoreboard #(.NREGS(NREGS), .REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_valid    (id_valid),
        .id_long_lat (id_long_lat),
        .flush       (flush),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .stall       (stall),
        .busy        (busy),
        .pending_cnt (pending_cnt),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: at the falling edge, compare every expectation stamped for this cycle.
    always @(negedge clk) begin
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            exp_t        e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.kind)
                K_STALL: act = {31'b0, stall};
                K_BUSY:  act = busy;
                K_CNT:   act = 32'(pending_cnt);
                default: act = {31'b0, err_timeout};
            endcase
            checks++;
            if (act !== e.val || e.cyc != cyc) begin
                failures++;
                $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", e.name, cyc, act, e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input int kind, input logic [31:0] val, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = '0; id_valid = 0; id_long_lat = 0; flush = 0;
        wb_valid = 0; wb_rd = '0;
    endtask

    task automatic issue_long(input logic [REG_W-1:0] rd);
        idle();
        id_valid = 1; id_long_lat = 1; id_rd = rd;
    endtask

    initial begin
        rst = 1;
        idle();
        tick();
        tick();

        // 1: reset state
        rst = 0;
        expect_val(K_BUSY,  32'h0, "rst_busy");
        expect_val(K_CNT,   32'd0, "rst_cnt");
        expect_val(K_STALL, 32'd0, "rst_stall");
        expect_val(K_ERR,   32'd0, "rst_err");
        #1;
        checks++;
        if (busy !== 32'h0) begin
            failures++;
            $display("FAIL imm_rst_busy got=0x%0h", busy);
        end
        checks++;
        if (pending_cnt !== 6'd0) begin
            failures++;
            $display("FAIL imm_rst_cnt got=%0d", pending_cnt);
        end
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL imm_rst_stall got=%0b", stall);
        end
        tick();

        // 2: load x5, dependent read stalls until writeback, bypass on wb cycle
        issue_long(5'd5);
        expect_val(K_STALL, 32'd0, "ld5_issue_stall");
        tick();
        idle(); id_valid = 1; id_rs1 = 5'd5; id_rs1_used = 1;
        expect_val(K_STALL, 32'd1, "raw5_stall_c1");
        expect_val(K_BUSY,  32'h20, "raw5_busy_c1");
        expect_val(K_CNT,   32'd1, "raw5_cnt_c1");
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL imm_raw5_stall got=%0b", stall);
        end
        checks++;
        if (busy !== 32'h20) begin
            failures++;
            $display("FAIL imm_raw5_busy got=0x%0h", busy);
        end
        tick();
        expect_val(K_STALL, 32'd1, "raw5_stall_c2");
        tick();
        expect_val(K_STALL, 32'd1, "raw5_stall_c3");
        tick();
        wb_valid = 1; wb_rd = 5'd5;
        expect_val(K_STALL, 32'd0, "raw5_bypass_c4");
        tick();
        wb_valid = 0;
        expect_val(K_BUSY,  32'h0, "raw5_busy_c5");
        expect_val(K_CNT,   32'd0, "raw5_cnt_c5");
        expect_val(K_STALL, 32'd0, "raw5_stall_c5");
        tick();

        // 3: same-cycle writeback and reissue of x7: set wins
        issue_long(5'd7);
        tick();
        issue_long(5'd7); wb_valid = 1; wb_rd = 5'd7;
        expect_val(K_BUSY,  32'h80, "x7_busy_before");
        expect_val(K_STALL, 32'd0, "x7_reissue_stall");
        tick();
        idle();
        expect_val(K_BUSY, 32'h80, "x7_busy_after");
        expect_val(K_CNT,  32'd1, "x7_cnt_after");
        wb_valid = 1; wb_rd = 5'd7;
        tick();
        idle();
        expect_val(K_BUSY, 32'h0, "x7_cleared");
        tick();

        // 4: x0 never becomes busy; wb to x0 ignored
        issue_long(5'd0);
        expect_val(K_STALL, 32'd0, "x0_issue_stall");
        tick();
        idle(); id_valid = 1; id_rs1_used = 1; id_rs2_used = 1;
        wb_valid = 1; wb_rd = 5'd0;
        expect_val(K_BUSY,  32'h0, "x0_busy");
        expect_val(K_CNT,   32'd0, "x0_cnt");
        expect_val(K_STALL, 32'd0, "x0_read_stall");
        tick();

        // 5: flush suppresses issue and stall, keeps existing busy bits
        issue_long(5'd3);
        tick();
        issue_long(5'd9); flush = 1; id_rs2 = 5'd3; id_rs2_used = 1;
        expect_val(K_BUSY,  32'h8, "flush_busy_before");
        expect_val(K_STALL, 32'd0, "flush_stall");
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL imm_flush_stall got=%0b", stall);
        end
        checks++;
        if (busy !== 32'h8) begin
            failures++;
            $display("FAIL imm_flush_busy got=0x%0h", busy);
        end
        tick();
        idle(); id_valid = 1; id_rs2 = 5'd3; id_rs2_used = 1;
        expect_val(K_BUSY,  32'h8, "flush_busy_after");
        expect_val(K_CNT,   32'd1, "flush_cnt_after");
        expect_val(K_STALL, 32'd1, "noflush_rs2_stall");
        tick();
        idle(); wb_valid = 1; wb_rd = 5'd3;
        tick();
        idle();
        expect_val(K_BUSY, 32'h0, "x3_cleared");
        // wb to an idle register: no change, no error
        wb_valid = 1; wb_rd = 5'd20;
        tick();
        idle();
        expect_val(K_BUSY, 32'h0, "wb_idle_busy");
        expect_val(K_CNT,  32'd0, "wb_idle_cnt");
        tick();

        // 6: x12 held busy past TIMEOUT; WAW stall; sticky error
        issue_long(5'd12);
        tick();
        issue_long(5'd12);
        expect_val(K_STALL, 32'd1, "waw12_stall");
        expect_val(K_ERR,   32'd0, "err_early");
        tick();
        idle();
        repeat (TIMEOUT - 12) tick();
        expect_val(K_ERR, 32'd0, "err_before_timeout");
        expect_val(K_CNT, 32'd1, "x12_cnt");
        repeat (20) tick();
        expect_val(K_ERR, 32'd1, "err_after_timeout");
        checks++;
        if (err_timeout !== 1'b1) begin
            failures++;
            $display("FAIL imm_err_after_timeout got=%0b", err_timeout);
        end
        wb_valid = 1; wb_rd = 5'd12;
        tick();
        idle();
        expect_val(K_BUSY, 32'h0, "x12_cleared");
        expect_val(K_ERR,  32'd1, "err_sticky1");
        tick();
        tick();
        expect_val(K_ERR, 32'd1, "err_sticky2");
        tick();

        // Bounded drain of the scoreboard queue
        for (int i = 0; i < 10 && q.size() != 0; i++) tick();
        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s never_checked want=0x%0h", e.name, e.val);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
